// File: rtl/case_bist_if.sv
// Bus between the case-network BIST controller and whatever hosts it.
// The host drives start/abort/golden and returns the case-network response.
// The controller drives the pattern, the status flags, the signature and a
// debug copy of its FSM state.
//
// Handshake: start is a single-cycle request. It is honoured only when the
// controller is idle or done, and is ignored while busy. abort is sampled
// every cycle and overrides start. done stays high until the next start or
// abort, and pass is only meaningful while done is high.
interface case_bist_if;
    logic        start;
    logic        abort;
    logic [15:0] golden;
    logic [4:0]  resp;
    logic [9:0]  pat;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [1:0]  state;

    modport master (
        output start, abort, golden, resp,
        input  pat, busy, done, pass, signature, state
    );

    modport slave (
        input  start, abort, golden, resp,
        output pat, busy, done, pass, signature, state
    );
endinterface

// File: rtl/case_bist_ctrl.sv
// BIST controller for a 10-input / 5-output combinational case network.
// A 10-bit LFSR (x^10 + x^7 + 1) supplies the patterns. The responses are
// compacted into a 16-bit MISR (poly 0x1021), which is compared against a
// golden signature once the run has finished.
//
// Optional feature, macro CASE_BIST_ZERO_PAT_EN: one extra RUN cycle follows
// the LFSR patterns. In that cycle the all-zero pattern is driven and its
// response is absorbed. This covers the single input code the LFSR can
// never produce.
module case_bist_ctrl #(
    parameter int         PATTERNS = 1023,
    parameter logic [9:0] SEED     = 10'h001
) (
    input  logic       clk,
    input  logic       rst_n,
    case_bist_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [9:0] LAST_CNT = 10'(PATTERNS - 1);

    state_t      state_q, state_d;
    logic [9:0]  pat_q, pat_d;
    logic [15:0] sig_q, sig_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [9:0]  lfsr_next;
    logic [15:0] misr_next;
`ifdef CASE_BIST_ZERO_PAT_EN
    logic        zero_q, zero_d;
`endif

    // Next LFSR pattern and next MISR value. The response is absorbed in the
    // same cycle as the pattern that produced it.
    always_comb begin
        lfsr_next = {pat_q[8:0], pat_q[9] ^ pat_q[6]};
        misr_next = {sig_q[14:0], 1'b0}
                  ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                  ^ {11'b0, bus.resp};
    end

    // Next-state and datapath update; abort overrides everything else.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
`ifdef CASE_BIST_ZERO_PAT_EN
        zero_d  = zero_q;
`endif
        if (bus.abort) begin
            state_d = IDLE;
            pat_d   = SEED;
            sig_d   = 16'h0000;
            cnt_d   = 10'd0;
`ifdef CASE_BIST_ZERO_PAT_EN
            zero_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d = RUN;
                        pat_d   = SEED;
                        sig_d   = 16'h0000;
                        cnt_d   = 10'd0;
`ifdef CASE_BIST_ZERO_PAT_EN
                        zero_d  = 1'b0;
`endif
                    end
                end
                RUN: begin
                    sig_d = misr_next;
`ifdef CASE_BIST_ZERO_PAT_EN
                    if (zero_q) begin
                        // Zero-pattern cycle: its response was absorbed above.
                        state_d = DONE;
                        zero_d  = 1'b0;
                    end else begin
                        pat_d = lfsr_next;
                        cnt_d = cnt_q + 10'd1;
                        if (cnt_q == LAST_CNT) begin
                            pat_d  = 10'h000;
                            zero_d = 1'b1;
                        end
                    end
`else
                    pat_d = lfsr_next;
                    cnt_d = cnt_q + 10'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= SEED;
            sig_q   <= 16'h0000;
            cnt_q   <= 10'd0;
`ifdef CASE_BIST_ZERO_PAT_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
`ifdef CASE_BIST_ZERO_PAT_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign bus.pat       = pat_q;
    assign bus.signature = sig_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = (state_q == DONE) && (sig_q == bus.golden);
    assign bus.state     = state_q;

endmodule

// File: doc/case_bist_ctrl.md
Name: case_bist_ctrl

Overview:
Sequential built-in self-test controller for the combinational logic case networks (10 inputs, 5 outputs) used in the logic-synthesis flow.
- Generates pseudo-random input patterns with a 10-bit LFSR and drives them to the case network.
- Compacts the network's 5-bit responses into a 16-bit MISR signature and compares it against a golden value.
- Sits on the other side of the network's interface: it writes the inputs and reads the outputs, so pre- and post-synthesis netlists can be checked for equivalence in silicon or in simulation.

Parameters:
- PATTERNS, 1023, number of patterns applied per run; legal range 1..1023.
- SEED, 10'h001, LFSR start value; must be non-zero.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- abort  input  1  synchronous abort; returns to IDLE.
- golden  input  16  expected signature, sampled in DONE.
- resp  input  5  case-network outputs {y5,y4,y3,y2,y1}; combinational function of pat.
- pat  output  10  case-network inputs {j..a}, bit 0 = a; the LFSR register.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  valid while done; 1 when signature == golden.
- signature  output  16  MISR register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pat=SEED, signature=16'h0000, counter=0, busy=0, done=0, pass=0.
- States are IDLE, RUN and DONE.
- IDLE/DONE + start:
  - next edge: pat<=SEED, signature<=0, cnt<=0, state<=RUN.
  - DONE clears on that same edge.
- RUN, each cycle:
  - signature <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {11'b0,resp}.
  - pat <= {pat[8:0], pat[9]^pat[6]}, i.e. x^10+x^7+1, maximal period 1023.
  - cnt <= cnt+1.
  - resp is sampled in the same cycle as the pat it belongs to; no pipeline delay.
- RUN when cnt==PATTERNS-1: the final absorb happens, then state<=DONE.
  - Total run = exactly PATTERNS cycles with busy=1.
  - done rises on the cycle after the last absorb.
- DONE:
  - signature and pat hold.
  - done=1; pass = (signature==golden), computed combinationally from the current golden.
- start while RUN: ignored.
- abort: any state -> IDLE on the next edge; signature and pat restored to reset values.
  - abort and start in the same cycle: abort wins.
- Async reset mid-RUN: immediate return to reset values; no partial done.
- The LFSR never reaches 0 from a non-zero SEED. An all-zero pat is produced only by the optional feature below.
- pat, busy, done and signature are registered outputs. pass is combinational from registered signature and the golden input.

Optional Feature:
Macro CASE_BIST_ZERO_PAT_EN.
- Defined:
  - After the PATTERNS LFSR cycles, one extra RUN cycle drives pat=10'h000 and absorbs its resp.
  - Run length = PATTERNS+1 cycles. The LFSR is not advanced during the zero cycle.
- Undefined: no extra cycle; pat is never zero.

Test Plan:
1. Reset, start, PATTERNS=8 -> pat sequence 001,002,004,008,010,020,040,081; busy high exactly 8 cycles; done rises on cycle 9.
2. resp tied 5'h00, PATTERNS=4 -> signature=16'h0000; pass=1 with golden=0, pass=0 with golden=16'h0001.
3. resp tied 5'h01, PATTERNS=2 -> signature goes 0001 then 0003; DONE holds 16'h0003.
4. PATTERNS=1023 -> pat returns to 10'h001 on the edge entering DONE; no zero pat observed (macro off). With CASE_BIST_ZERO_PAT_EN, busy lasts 1024 cycles and the last pat is 10'h000.
5. Assert abort at RUN cycle 5 together with start -> IDLE next edge, signature=0, pat=001, done=0; a fresh start then reproduces scenario 1.
6. Pull rst_n low mid-RUN asynchronously, away from the clock edge -> outputs reach reset values immediately; start pulsed while busy has no effect on the count.
